// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with a start/busy/done handshake.
// The operation takes one Booth step per clock over WIDTH+1 internal bits, in signed or unsigned mode.
module booth_mult_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_en,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  // One guard bit makes unsigned operands and -2^(W-1) as multiplicand exact.
  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [N-1:0]    a;
  logic [N-1:0]    q;
  logic [N-1:0]    m;
  logic            q_1;

  logic [N-1:0]    a_op;
  logic [N-1:0]    a_sh;
  logic [N-1:0]    q_sh;
  logic            q1_sh;

  function automatic logic [N-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
    return {s & v[WIDTH-1], v};
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    a_op = a;
    case ({q[0], q_1})
      2'b01:   a_op = a + m;
      2'b10:   a_op = a - m;
      default: a_op = a;
    endcase
    // Arithmetic shift of {A,Q,q_1}: old q_1 falls off, A's sign bit is replicated.
    {a_sh, q_sh, q1_sh} = {a_op[N-1], a_op, q};
  end

  // busy/done are flops that follow the state one edge later, so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      a     <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      busy <= (state == RUN);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a     <= '0;
            q     <= extend(x, signed_en);
            m     <= extend(y, signed_en);
            q_1   <= 1'b0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a     <= a_sh;
          q     <= q_sh;
          q_1   <= q1_sh;
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          // Low 2*WIDTH bits of {A,Q}: all of Q plus the bottom WIDTH-1 bits of A.
          z     <= {a[WIDTH-2:0], q};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed WIDTH=4 cases plus a WIDTH=8 random back-to-back sweep.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, se4;
  logic [3:0]  x4, y4;
  logic        busy4, done4;
  logic [7:0]  z4;

  logic        start8, se8;
  logic [7:0]  x8, y8;
  logic        busy8, done8;
  logic [15:0] z8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_en(se4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .z(z4)
  );

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_en(se8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .z(z8)
  );

  // Reference: plain integer multiply of the operands interpreted per mode, truncated to 2w bits.
  function automatic longint ref_prod(input int w, input longint xv, input longint yv, input bit s);
    longint xi, yi, p;
    xi = xv;
    yi = yv;
    if (s && xv[w-1]) xi = xi - (longint'(1) << w);
    if (s && yv[w-1]) yi = yi - (longint'(1) << w);
    p = xi * yi;
    return p & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation: checks latency, busy length, product and that z holds afterwards.
  task automatic op4(input string tag, input bit s, input logic [3:0] xv, input logic [3:0] yv);
    int lat, nbusy;
    bit seen;
    longint e;
    e = ref_prod(4, xv, yv, s);
    @(negedge clk);
    start4 = 1'b1; se4 = s; x4 = xv; y4 = yv;
    @(posedge clk);
    #1 start4 = 1'b0;
    lat = 0; nbusy = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (busy4) nbusy++;
      if (done4) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, "_latency"}, lat, 6);
    check({tag, "_busy_cycles"}, nbusy, 5);
    check({tag, "_z"}, z4, e);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done4, 1'b0);
    check({tag, "_z_hold"}, z4, e);
  endtask

  initial begin
    int ndone, last_done, nops;
    bit rs;
    logic [3:0] rx, ry;
    longint expq[$];
    longint e;

    rst = 1'b1;
    start4 = 1'b0; se4 = 1'b0; x4 = '0; y4 = '0;
    start8 = 1'b0; se8 = 1'b0; x8 = '0; y8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy4", busy4, 1'b0);
    check("reset_done4", done4, 1'b0);
    check("reset_z4", z4, 8'h00);
    check("reset_busy8", busy8, 1'b0);
    check("reset_done8", done8, 1'b0);
    check("reset_z8", z8, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    op4("s_3x5", 1'b1, 4'h3, 4'h5);
    check("s_3x5_const", z4, 8'h0F);
    op4("s_m8xm8", 1'b1, 4'h8, 4'h8);
    check("s_m8xm8_const", z4, 8'h40);
    op4("s_m1x7", 1'b1, 4'hF, 4'h7);
    check("s_m1x7_const", z4, 8'hF9);
    op4("u_15x15", 1'b0, 4'hF, 4'hF);
    check("u_15x15_const", z4, 8'hE1);
    op4("u_8x1", 1'b0, 4'h8, 4'h1);
    check("u_8x1_const", z4, 8'h08);
    op4("s_0x9", 1'b1, 4'h0, 4'h9);
    op4("u_7x0", 1'b0, 4'h7, 4'h0);
    op4("s_7xm8", 1'b1, 4'h7, 4'h8);
    for (int k = 0; k < 6; k++) begin
      rs = 1'($urandom_range(0, 1));
      rx = 4'($urandom);
      ry = 4'($urandom);
      op4("rand4", rs, rx, ry);
    end

    // A second start during RUN, with changed operands, must be ignored.
    @(negedge clk);
    start4 = 1'b1; se4 = 1'b1; x4 = 4'h3; y4 = 4'h5;
    @(posedge clk);
    #1 start4 = 1'b1; x4 = 4'h2; y4 = 4'h7; se4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 start4 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        ndone++;
        check("midrun_start_z", z4, 8'h0F);
      end
    end
    check("midrun_start_done_count", ndone, 1);
    check("midrun_start_z_final", z4, 8'h0F);

    // Reset two cycles into RUN aborts at once and clears z.
    @(negedge clk);
    start4 = 1'b1; se4 = 1'b0; x4 = 4'hF; y4 = 4'hF;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy_before", busy4, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy4, 1'b0);
    check("abort_done", done4, 1'b0);
    check("abort_z", z4, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done4) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_z_after", z4, 8'h00);

    // WIDTH=8 back-to-back sweep with start held high; new operands presented in each done cycle.
    @(negedge clk);
    x8 = 8'($urandom); y8 = 8'($urandom); se8 = 1'($urandom_range(0, 1));
    expq.push_back(ref_prod(8, x8, y8, se8));
    start8 = 1'b1;
    nops = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 2000 && nops < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        e = (expq.size() > 0) ? expq.pop_front() : -1;
        check("sweep8_z", z8, e);
        if (last_done >= 0) check("sweep8_spacing", cyc - last_done, 11);
        last_done = cyc;
        nops++;
        if (nops < 20) begin
          x8 = 8'($urandom); y8 = 8'($urandom); se8 = 1'($urandom_range(0, 1));
          expq.push_back(ref_prod(8, x8, y8, se8));
        end else begin
          start8 = 1'b0;
        end
      end
    end
    check("sweep8_ops", nops, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
